// File: rtl/tug_of_war_arena.sv
// Two-player tug-of-war: a one-hot rope light moves toward whoever pulls.
// Rounds are won at the ends; first to WIN_ROUNDS takes the match.
module tug_of_war_arena #(
  parameter int NUM_LIGHTS  = 9,
  parameter int WIN_ROUNDS  = 3,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l_press,
  input  logic                  r_press,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    l_score,
  output logic [SCORE_W-1:0]    r_score,
  output logic                  round_done,
  output logic                  round_winner,
  output logic                  match_over,
  output logic                  match_winner
);

  localparam int PW = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0]      CENTER = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0]      LAST   = PW'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_ROUNDS);
  localparam logic [HW-1:0]      HOLD_L = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLAY,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               l_press_q, r_press_q;
  logic [SCORE_W-1:0] l_score_q, l_score_d;
  logic [SCORE_W-1:0] r_score_q, r_score_d;
  logic               round_done_q, round_done_d;
  logic               round_winner_q, round_winner_d;
  logic               match_over_q, match_over_d;
  logic               match_winner_q, match_winner_d;

  logic l_pull, r_pull;
  logic [SCORE_W-1:0] new_score;

  // Rising-edge detect; a button held through reset yields no pull.
  assign l_pull = l_press & ~l_press_q;
  assign r_pull = r_press & ~r_press_q;

  // State register: FSM state, rope position, scores and press history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_PLAY;
      pos_q          <= CENTER;
      hold_q         <= '0;
      l_press_q      <= 1'b1;
      r_press_q      <= 1'b1;
      l_score_q      <= '0;
      r_score_q      <= '0;
      round_done_q   <= 1'b0;
      round_winner_q <= 1'b0;
      match_over_q   <= 1'b0;
      match_winner_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      hold_q         <= hold_d;
      l_press_q      <= l_press;
      r_press_q      <= r_press;
      l_score_q      <= l_score_d;
      r_score_q      <= r_score_d;
      round_done_q   <= round_done_d;
      round_winner_q <= round_winner_d;
      match_over_q   <= match_over_d;
      match_winner_q <= match_winner_d;
    end
  end

  // Next-state: rope movement, round/match wins and the post-round pause.
  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    hold_d         = hold_q;
    l_score_d      = l_score_q;
    r_score_d      = r_score_q;
    round_done_d   = 1'b0;
    round_winner_d = round_winner_q;
    match_over_d   = match_over_q;
    match_winner_d = match_winner_q;
    new_score      = '0;
    case (state_q)
      S_PLAY: begin
        if (l_pull && !r_pull) begin
          if (pos_q == LAST) begin
            new_score      = l_score_q + SCORE_W'(1);
            l_score_d      = new_score;
            round_done_d   = 1'b1;
            round_winner_d = 1'b1;
            if (new_score == WIN_S) begin
              state_d        = S_DONE;
              match_over_d   = 1'b1;
              match_winner_d = 1'b1;
            end else begin
              state_d = S_PAUSE;
              hold_d  = HOLD_L;
            end
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else if (r_pull && !l_pull) begin
          if (pos_q == '0) begin
            new_score      = r_score_q + SCORE_W'(1);
            r_score_d      = new_score;
            round_done_d   = 1'b1;
            round_winner_d = 1'b0;
            if (new_score == WIN_S) begin
              state_d        = S_DONE;
              match_over_d   = 1'b1;
              match_winner_d = 1'b0;
            end else begin
              state_d = S_PAUSE;
              hold_d  = HOLD_L;
            end
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
      end
      S_PAUSE: begin
        if (hold_q == '0) begin
          pos_d   = CENTER;
          state_d = S_PLAY;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Outputs: rope light only while playing; everything else registered.
  always_comb begin
    lights = '0;
    if (state_q == S_PLAY) begin
      lights = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << pos_q;
    end
  end

  assign l_score      = l_score_q;
  assign r_score      = r_score_q;
  assign round_done   = round_done_q;
  assign round_winner = round_winner_q;
  assign match_over   = match_over_q;
  assign match_winner = match_winner_q;

endmodule

// File: tb/tb_tug_of_war_arena.sv
// Bench for tug_of_war_arena: vector table with a scoreboard queue,
// plus reset sequences (including reset mid-pause with a held button).
module tb_tug_of_war_arena;

  localparam int NL = 9;
  localparam int WR = 2;
  localparam int SW = 3;
  localparam int HC = 4;
  localparam int OW = NL + 2 * SW + 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          l_press;
  logic          r_press;
  logic [NL-1:0] lights;
  logic [SW-1:0] l_score;
  logic [SW-1:0] r_score;
  logic          round_done;
  logic          round_winner;
  logic          match_over;
  logic          match_winner;

  tug_of_war_arena #(
    .NUM_LIGHTS (NL),
    .WIN_ROUNDS (WR),
    .SCORE_W    (SW),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .l_press     (l_press),
    .r_press     (r_press),
    .lights      (lights),
    .l_score     (l_score),
    .r_score     (r_score),
    .round_done  (round_done),
    .round_winner(round_winner),
    .match_over  (match_over),
    .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          l;
    logic          r;
    logic [NL-1:0] lt;
    logic [SW-1:0] ls;
    logic [SW-1:0] rs;
    logic          rd;
    logic          rw;
    logic          mo;
    logic          mw;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [OW-1:0] observed();
    return {lights, l_score, r_score,
            round_done, round_winner, match_over, match_winner};
  endfunction

  function automatic void add(logic l, logic r, logic [NL-1:0] lt,
                              logic [SW-1:0] ls, logic [SW-1:0] rs,
                              logic rd, logic rw, logic mo, logic mw);
    vec_t v;
    v.l = l; v.r = r; v.lt = lt; v.ls = ls; v.rs = rs;
    v.rd = rd; v.rw = rw; v.mo = mo; v.mw = mw;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [OW-1:0] got, logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got lt/ls/rs/rd/rw/mo/mw=%b want %b", nm, got, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic run_table(string tag);
    logic [OW-1:0] exp;
    foreach (vecs[i]) begin
      @(negedge clk);
      l_press = vecs[i].l;
      r_press = vecs[i].r;
      sb.push_back({vecs[i].lt, vecs[i].ls, vecs[i].rs,
                    vecs[i].rd, vecs[i].rw, vecs[i].mo, vecs[i].mw});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s[%0d]: scoreboard empty", tag, i);
      end else begin
        exp = sb.pop_front();
        check($sformatf("%s[%0d]", tag, i), observed(), exp);
      end
    end
    vecs.delete();
  endtask

  // Assert reset between edges and check the cleared state at once.
  task automatic do_reset(string nm);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check(nm, observed(), {9'h010, {SW{1'b0}}, {SW{1'b0}}, 4'b0000});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    l_press = 1'b0;
    r_press = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", observed(),
          {9'h010, {SW{1'b0}}, {SW{1'b0}}, 4'b0000});
    @(negedge clk);
    reset = 1'b0;

    // Held left press -> one move; simultaneous presses -> no move.
    add(0, 0, 9'h010, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 9'h020, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h020, 0, 0, 0, 0, 0, 0);
    add(1, 1, 9'h020, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h020, 0, 0, 0, 0, 0, 0);
    add(0, 1, 9'h010, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h010, 0, 0, 0, 0, 0, 0);
    // Right pulls to the edge, then the round win.
    add(0, 1, 9'h008, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h008, 0, 0, 0, 0, 0, 0);
    add(0, 1, 9'h004, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h004, 0, 0, 0, 0, 0, 0);
    add(0, 1, 9'h002, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h002, 0, 0, 0, 0, 0, 0);
    add(0, 1, 9'h001, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h001, 0, 0, 0, 0, 0, 0);
    add(0, 1, 9'h000, 0, 1, 1, 0, 0, 0);
    // Pause: pulls ignored, four dark cycles total, then centre.
    add(1, 0, 9'h000, 0, 1, 0, 0, 0, 0);
    add(0, 1, 9'h000, 0, 1, 0, 0, 0, 0);
    add(0, 0, 9'h000, 0, 1, 0, 0, 0, 0);
    add(1, 0, 9'h010, 0, 1, 0, 0, 0, 0);
    add(0, 0, 9'h010, 0, 1, 0, 0, 0, 0);
    // Second right round wins the match.
    add(0, 1, 9'h008, 0, 1, 0, 0, 0, 0);
    add(0, 0, 9'h008, 0, 1, 0, 0, 0, 0);
    add(0, 1, 9'h004, 0, 1, 0, 0, 0, 0);
    add(0, 0, 9'h004, 0, 1, 0, 0, 0, 0);
    add(0, 1, 9'h002, 0, 1, 0, 0, 0, 0);
    add(0, 0, 9'h002, 0, 1, 0, 0, 0, 0);
    add(0, 1, 9'h001, 0, 1, 0, 0, 0, 0);
    add(0, 0, 9'h001, 0, 1, 0, 0, 0, 0);
    add(0, 1, 9'h000, 0, 2, 1, 0, 1, 0);
    // Match over: everything frozen.
    add(0, 0, 9'h000, 0, 2, 0, 0, 1, 0);
    add(1, 0, 9'h000, 0, 2, 0, 0, 1, 0);
    add(0, 0, 9'h000, 0, 2, 0, 0, 1, 0);
    add(0, 1, 9'h000, 0, 2, 0, 0, 1, 0);
    add(0, 0, 9'h000, 0, 2, 0, 0, 1, 0);
    add(1, 0, 9'h000, 0, 2, 0, 0, 1, 0);
    run_table("match_r");

    l_press = 1'b0;
    r_press = 1'b0;
    do_reset("reset_from_done");

    // Left side round win, then reset mid-pause with r held.
    add(1, 0, 9'h020, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h020, 0, 0, 0, 0, 0, 0);
    add(1, 0, 9'h040, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h040, 0, 0, 0, 0, 0, 0);
    add(1, 0, 9'h080, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h080, 0, 0, 0, 0, 0, 0);
    add(1, 0, 9'h100, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h100, 0, 0, 0, 0, 0, 0);
    add(1, 0, 9'h000, 1, 0, 1, 1, 0, 0);
    add(0, 1, 9'h000, 1, 0, 0, 1, 0, 0);
    run_table("round_l");

    do_reset("reset_mid_pause");

    // r still held from before reset: no pull until it re-rises.
    add(0, 1, 9'h010, 0, 0, 0, 0, 0, 0);
    add(0, 1, 9'h010, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h010, 0, 0, 0, 0, 0, 0);
    add(0, 1, 9'h008, 0, 0, 0, 0, 0, 0);
    add(0, 0, 9'h008, 0, 0, 0, 0, 0, 0);
    run_table("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
